mac_sequencer: RTL and testbench
================================

Name: mac_sequencer

Overview:
Command responder on the far side of the control fsm. It consumes the synchronised clear and run pulses that the fsm emits and sequences one multiply-accumulate pass over DEPTH operand pairs. It fetches pairs from a 1-cycle-latency operand store, accumulates their products, and reports busy/done status back to the controller.

Parameters:
WIDTH, 4, operand width (unsigned) of A_IN and B_IN
DEPTH, 8, number of operand pairs per pass (>=2)
ACC_WIDTH, 8, accumulator width; may be narrower than 2*WIDTH+clog2(DEPTH)

Ports:
CLK  input  1  system clock, rising edge
RESET_IN  input  1  asynchronous, active-low reset
CLR_IN  input  1  synchronous clear command pulse from fsm (active-high)
RUN_IN  input  1  start command pulse from fsm (active-high)
A_IN  input  WIDTH  operand A, valid 1 cycle after ADDR_OUT
B_IN  input  WIDTH  operand B, valid 1 cycle after ADDR_OUT
ADDR_OUT  output  clog2(DEPTH)  operand store read address
RD_OUT  output  1  read strobe qualifying ADDR_OUT
ACC_OUT  output  ACC_WIDTH  accumulator value
BUSY_OUT  output  1  pass in progress
DONE_OUT  output  1  one-cycle pulse at pass completion

Behaviour:
- Reset (RESET_IN=0, async): state IDLE; ADDR_OUT=0, RD_OUT=0, ACC_OUT=0, BUSY_OUT=0, DONE_OUT=0. Outputs are registered.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - CLR_IN=1 -> ACC_OUT<=0, stay IDLE.
  - RUN_IN=1 -> ACC_OUT<=0, ADDR_OUT<=0, RD_OUT<=1, BUSY_OUT<=1, go FETCH.
  - A run always restarts from 0; it does not continue the previous total.
- FETCH:
  - Each cycle ADDR_OUT increments.
  - From the 2nd FETCH cycle onward, ACC_OUT<=ACC_OUT+A_IN*B_IN, using operands of the previous address.
  - When ADDR_OUT==DEPTH-1 has been issued -> RD_OUT<=0, go DRAIN.
- DRAIN: accumulate the last pair; BUSY_OUT<=0, DONE_OUT<=1, go DONE.
- DONE: DONE_OUT<=0, go IDLE. ACC_OUT holds until the next CLR_IN or RUN_IN.
- Latency: RUN_IN sampled at edge 0 -> DONE_OUT high after edge DEPTH+1. BUSY_OUT is high for exactly DEPTH+1 cycles.
- RUN_IN while BUSY_OUT=1 is ignored, with no queueing.
- CLR_IN in any non-IDLE state aborts the pass:
  - ACC_OUT<=0, RD_OUT<=0, BUSY_OUT<=0, ADDR_OUT<=0, go IDLE.
  - No DONE_OUT pulse.
- CLR_IN and RUN_IN together: CLR_IN wins and RUN_IN is dropped.
- Arithmetic:
  - Products are unsigned, 2*WIDTH bits, zero-extended or truncated to ACC_WIDTH.
  - Default overflow wraps modulo 2^ACC_WIDTH.
- ADDR_OUT never exceeds DEPTH-1.
- Reset asserted mid-pass returns all outputs to reset values immediately (async).

Optional Feature:
MAC_SATURATE_EN
- Defined: the accumulator clamps at 2^ACC_WIDTH-1 and stays there for the rest of the pass. OVF_OUT (output, 1) is added; it is set on the first clamp, cleared by CLR_IN, RUN_IN and reset.
- Undefined: modulo wrap, and no OVF_OUT port.

Decomposition:
- Package mac_pkg:
  - state encoding constants (IDLE=2'd0, FETCH=2'd1, DRAIN=2'd2, DONE=2'd3)
  - a clog2 function
  - default WIDTH/DEPTH/ACC_WIDTH constants shared with the fsm and datapath
- Sub-module mac_acc: registered multiply-accumulate with clear, enable and the saturation option. The sequencer FSM drives its enable and clear.

Test Plan:
- Reset: assert RESET_IN=0 mid-FETCH (no clock edge) -> all outputs 0 immediately.
- Basic pass: DEPTH=8, A=i+1, B=2 at address i, pulse RUN_IN -> ADDR_OUT 0..7 on consecutive cycles, DONE_OUT 1 cycle after edge 9, ACC_OUT=72, BUSY_OUT high 9 cycles.
- Wrap: WIDTH=4, ACC_WIDTH=8, all operands 15 -> 8*225=1800, ACC_OUT=1800 mod 256=8. With MAC_SATURATE_EN: ACC_OUT=255, OVF_OUT=1.
- Abort: CLR_IN at 4th FETCH cycle -> BUSY_OUT=0, ACC_OUT=0, no DONE_OUT pulse, state IDLE next cycle.
- Collisions:
  - RUN_IN re-pulsed during BUSY -> ignored, same result as the basic pass.
  - RUN_IN and CLR_IN in the same cycle in IDLE -> stays IDLE, ACC_OUT=0.
- Hold and restart: after DONE, ACC_OUT holds 72 for 10 idle cycles. A second RUN_IN restarts from 0, not 144.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC sequencer, its datapath and the fsm.
package mac_pkg;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_ACC_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mac_state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_acc.sv
// Registered multiply-accumulate with clear and enable.
// MAC_SATURATE_EN selects clamping with a sticky overflow flag.
module mac_acc
  import mac_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
`ifdef MAC_SATURATE_EN
  output logic                 o_ovf,
`endif
  output logic [ACC_WIDTH-1:0] o_acc
);

  logic [2*WIDTH-1:0]   w_prod;
  logic [ACC_WIDTH-1:0] r_acc;

  assign w_prod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
  assign o_acc  = r_acc;

`ifdef MAC_SATURATE_EN
  // Sum is wide enough that no addition can wrap before the clamp test.
  localparam int SW = ACC_WIDTH + 2*WIDTH + 1;

  logic [SW-1:0] w_sum;
  logic          w_over;
  logic          r_ovf;

  assign w_sum  = SW'(r_acc) + SW'(w_prod);
  assign w_over = |w_sum[SW-1:ACC_WIDTH];
  assign o_ovf  = r_ovf;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_en) begin
      if (w_over) begin
        r_acc <= '1;
        r_ovf <= 1'b1;
      end else begin
        r_acc <= w_sum[ACC_WIDTH-1:0];
      end
    end
  end
`else
  logic [ACC_WIDTH-1:0] w_sum;

  assign w_sum = r_acc + ACC_WIDTH'(w_prod);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum;
    end
  end
`endif

endmodule

// File: rtl/mac_sequencer.sv
// Sequences one MAC pass over DEPTH operand pairs from a 1-cycle store.
// Define MAC_SATURATE_EN for a clamping accumulator and OVF_OUT.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RESET_IN,
  input  logic                    CLR_IN,
  input  logic                    RUN_IN,
  input  logic [WIDTH-1:0]        A_IN,
  input  logic [WIDTH-1:0]        B_IN,
  output logic [clog2(DEPTH)-1:0] ADDR_OUT,
  output logic                    RD_OUT,
  output logic [ACC_WIDTH-1:0]    ACC_OUT,
  output logic                    BUSY_OUT,
`ifdef MAC_SATURATE_EN
  output logic                    OVF_OUT,
`endif
  output logic                    DONE_OUT
);

  localparam int            AW   = clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  mac_state_e    r_state;
  logic [AW-1:0] r_addr;
  logic          r_rd;
  logic          r_busy;
  logic          r_done;
  logic          w_clr;
  logic          w_en;

  assign ADDR_OUT = r_addr;
  assign RD_OUT   = r_rd;
  assign BUSY_OUT = r_busy;
  assign DONE_OUT = r_done;

  // Address 0 is only on the bus during the first FETCH cycle,
  // so a non-zero address marks valid operands from the prior cycle.
  assign w_clr = CLR_IN | ((r_state == IDLE) & RUN_IN);
  assign w_en  = ((r_state == FETCH) & (r_addr != '0))
               | (r_state == DRAIN);

  always_ff @(posedge CLK or negedge RESET_IN) begin
    if (!RESET_IN) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!CLR_IN && RUN_IN) begin
            r_addr  <= '0;
            r_rd    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= FETCH;
          end
        end
        FETCH: begin
          if (CLR_IN) begin
            r_addr  <= '0;
            r_rd    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_addr == LAST) begin
            r_rd    <= 1'b0;
            r_state <= DRAIN;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        DRAIN: begin
          r_busy <= 1'b0;
          if (CLR_IN) begin
            r_addr  <= '0;
            r_rd    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (CLR_IN) begin
            r_addr <= '0;
          end
          r_state <= IDLE;
        end
      endcase
    end
  end

  mac_acc #(
    .WIDTH    (WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_acc (
    .i_clk  (CLK),
    .i_rst_n(RESET_IN),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .i_a    (A_IN),
    .i_b    (B_IN),
`ifdef MAC_SATURATE_EN
    .o_ovf  (OVF_OUT),
`endif
    .o_acc  (ACC_OUT)
  );

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: pass-level reference model plus directed cases.
// Covers both the wrapping and MAC_SATURATE_EN builds.
module tb_mac_sequencer;

  localparam int W       = 4;
  localparam int D       = 8;
  localparam int AWID    = 8;
  localparam int ACC_MAX = (1 << AWID) - 1;

  logic         CLK = 1'b0;
  logic         RESET_IN = 1'b0;
  logic         CLR_IN = 1'b0;
  logic         RUN_IN = 1'b0;
  logic [W-1:0] A_IN = '0;
  logic [W-1:0] B_IN = '0;
  logic [2:0]   ADDR_OUT;
  logic         RD_OUT;
  logic [AWID-1:0] ACC_OUT;
  logic         BUSY_OUT;
  logic         DONE_OUT;
`ifdef MAC_SATURATE_EN
  logic         OVF_OUT;
`endif

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  logic [W-1:0] memA [D];
  logic [W-1:0] memB [D];

  mac_sequencer #(
    .WIDTH(W), .DEPTH(D), .ACC_WIDTH(AWID)
  ) dut (
    .CLK(CLK), .RESET_IN(RESET_IN), .CLR_IN(CLR_IN),
    .RUN_IN(RUN_IN), .A_IN(A_IN), .B_IN(B_IN),
    .ADDR_OUT(ADDR_OUT), .RD_OUT(RD_OUT), .ACC_OUT(ACC_OUT),
    .BUSY_OUT(BUSY_OUT),
`ifdef MAC_SATURATE_EN
    .OVF_OUT(OVF_OUT),
`endif
    .DONE_OUT(DONE_OUT)
  );

  always #5 CLK = ~CLK;

  // Operand store: 1-cycle read latency
  always @(posedge CLK) begin
    if (RD_OUT) begin
      A_IN <= memA[ADDR_OUT];
      B_IN <= memB[ADDR_OUT];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Pass model: m_k = edges since the run was accepted, -1 when idle.
  int m_k = -1;
  int m_acc = 0;
  int m_addr = 0;
  bit m_ovf = 1'b0;

  function automatic void m_add(input int p);
    m_acc = m_acc + p;
`ifdef MAC_SATURATE_EN
    if (m_acc > ACC_MAX) begin
      m_acc = ACC_MAX;
      m_ovf = 1'b1;
    end
`else
    m_acc = m_acc % (ACC_MAX + 1);
`endif
  endfunction

  always @(posedge CLK or negedge RESET_IN) begin
    if (!RESET_IN) begin
      m_k = -1; m_acc = 0; m_addr = 0; m_ovf = 1'b0;
    end else if (CLR_IN) begin
      if (m_k >= 0) m_addr = 0;
      m_k = -1; m_acc = 0; m_ovf = 1'b0;
    end else if (m_k < 0) begin
      if (RUN_IN) begin
        m_k = 0; m_acc = 0; m_addr = 0; m_ovf = 1'b0;
      end
    end else begin
      m_k++;
      if (m_k >= 2 && m_k <= D + 1)
        m_add(int'(memA[m_k-2]) * int'(memB[m_k-2]));
      if (m_k <= D - 1) m_addr = m_k;
      if (m_k == D + 2) m_k = -1;
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("m_acc", ACC_OUT, m_acc);
      chk("m_addr", ADDR_OUT, m_addr);
      chk("m_rd", RD_OUT, (m_k >= 0 && m_k <= D - 1));
      chk("m_busy", BUSY_OUT, (m_k >= 0 && m_k <= D));
      chk("m_done", DONE_OUT, (m_k == D + 1));
`ifdef MAC_SATURATE_EN
      chk("m_ovf", OVF_OUT, m_ovf);
`endif
    end
  end

  task automatic run_pass(input bit repulse, output int busy_n,
                          output int done_at, output int acc_at);
    busy_n = 0; done_at = -1; acc_at = -1;
    RUN_IN = 1'b1;
    @(negedge CLK);
    RUN_IN = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i < D) chk("addr_seq", ADDR_OUT, i);
      if (BUSY_OUT) busy_n++;
      if (DONE_OUT) begin
        done_at = i;
        acc_at = ACC_OUT;
        break;
      end
      RUN_IN = repulse && (i == 3);
      @(negedge CLK);
    end
    RUN_IN = 1'b0;
    @(negedge CLK);
  endtask

  task automatic load_basic();
    for (int i = 0; i < D; i++) begin
      memA[i] = W'(i + 1);
      memB[i] = W'(2);
    end
  endtask

  int bn, da, acc;
  bit seen;

  initial begin
    load_basic();
    cmp_en = 1'b1;
    #11;
    chk("rst_acc", ACC_OUT, 0);
    chk("rst_busy", BUSY_OUT, 0);
    chk("rst_rd", RD_OUT, 0);
    @(negedge CLK);
    RESET_IN = 1'b1;
    @(negedge CLK);

    run_pass(1'b0, bn, da, acc);
    chk("basic_acc", acc, 72);
    chk("basic_busy_cycles", bn, 9);
    chk("basic_done_edge", da, 9);
    repeat (10) begin
      chk("hold_acc", ACC_OUT, 72);
      @(negedge CLK);
    end
    run_pass(1'b0, bn, da, acc);
    chk("restart_acc", acc, 72);
    run_pass(1'b1, bn, da, acc);
    chk("repulse_acc", acc, 72);
    chk("repulse_busy", bn, 9);

    for (int i = 0; i < D; i++) begin
      memA[i] = 4'hF; memB[i] = 4'hF;
    end
    run_pass(1'b0, bn, da, acc);
`ifdef MAC_SATURATE_EN
    chk("sat_acc", acc, 255);
    chk("sat_ovf", OVF_OUT, 1);
`else
    chk("wrap_acc", acc, 8);
`endif

    load_basic();
    RUN_IN = 1'b1;
    @(negedge CLK);
    RUN_IN = 1'b0;
    repeat (3) @(negedge CLK);
    CLR_IN = 1'b1;
    @(negedge CLK);
    CLR_IN = 1'b0;
    chk("abort_busy", BUSY_OUT, 0);
    chk("abort_acc", ACC_OUT, 0);
    chk("abort_rd", RD_OUT, 0);
    chk("abort_addr", ADDR_OUT, 0);
    seen = 1'b0;
    repeat (12) begin
      if (DONE_OUT) seen = 1'b1;
      @(negedge CLK);
    end
    chk("abort_nodone", seen, 0);

    run_pass(1'b0, bn, da, acc);
    CLR_IN = 1'b1; RUN_IN = 1'b1;
    @(negedge CLK);
    CLR_IN = 1'b0; RUN_IN = 1'b0;
    chk("clrrun_busy", BUSY_OUT, 0);
    chk("clrrun_acc", ACC_OUT, 0);
    @(negedge CLK);
    chk("clrrun_rd", RD_OUT, 0);

    RUN_IN = 1'b1;
    @(negedge CLK);
    RUN_IN = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RESET_IN = 1'b0;
    #1;
    chk("arst_acc", ACC_OUT, 0);
    chk("arst_addr", ADDR_OUT, 0);
    chk("arst_rd", RD_OUT, 0);
    chk("arst_busy", BUSY_OUT, 0);
    chk("arst_done", DONE_OUT, 0);
    @(negedge CLK);
    RESET_IN = 1'b1;
    @(negedge CLK);

    for (int c = 0; c < 2000; c++) begin
      CLR_IN = ($urandom_range(0, 24) == 0);
      RUN_IN = ($urandom_range(0, 4) == 0);
      if (m_k < 0 && $urandom_range(0, 1) == 1) begin
        memA[$urandom_range(0, D-1)] = W'($urandom);
        memB[$urandom_range(0, D-1)] = W'($urandom);
      end
      @(negedge CLK);
    end
    CLR_IN = 1'b0; RUN_IN = 1'b0;
    repeat (D + 4) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
